// File: rtl/wb_imc_pkg.sv
// wb_imc_pkg: IMC buffer address map, slave state encoding and mapped-offset check
package wb_imc_pkg;
    localparam logic [7:0] ADDR_IB = 8'h31;
    localparam logic [7:0] ADDR_WB = 8'h32;
    localparam logic [7:0] ADDR_OB = 8'h33;
    localparam logic [7:0] ADDR_IM = 8'h40;
    localparam logic [7:0] ADDR_SA = 8'h41;
    typedef enum logic [2:0] {IDLE, ACCESS, WAIT, ACK, ERR} state_t;
    function automatic logic is_mapped(input logic [7:0] a);
        return a inside {ADDR_IB, ADDR_WB, ADDR_OB, ADDR_IM, ADDR_SA};
    endfunction
endpackage

// File: rtl/wb_imc_slave_ctrl_rd_mux.sv
// wb_imc_rd_mux: selects OB or SA read data by buffer address, zero for any other offset
module wb_imc_rd_mux import wb_imc_pkg::*; #(
    parameter int WIDTH_ADD = 8
) (
    input  logic [WIDTH_ADD-1:0] i_addr,
    input  logic [31:0]          i_ob,
    input  logic [31:0]          i_sa,
    output logic [31:0]          o_data
);
    assign o_data = (i_addr == WIDTH_ADD'(ADDR_OB)) ? i_ob :
                    (i_addr == WIDTH_ADD'(ADDR_SA)) ? i_sa : '0;
endmodule

// File: rtl/wb_imc_slave_ctrl.sv
// wb_imc_slave_ctrl: Wishbone slave front-end for the IMC buffers; define WB_IMC_ERR_EN to add wbs_err_o for unmapped offsets
module wb_imc_slave_ctrl import wb_imc_pkg::*; #(
    parameter logic [31:0]          BASE_ADDR  = 32'h3000_0000,
    parameter int                   WIDTH_ADD  = 8,
    parameter int                   RD_LATENCY = 1,
    parameter logic [WIDTH_ADD-1:0] IDLE_ADDR  = '0
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 wbs_cyc_i,
    input  logic                 wbs_stb_i,
    input  logic                 wbs_we_i,
    input  logic [3:0]           wbs_sel_i,
    input  logic [31:0]          wbs_adr_i,
    input  logic [31:0]          wbs_dat_i,
    output logic                 wbs_ack_o,
`ifdef WB_IMC_ERR_EN
    output logic                 wbs_err_o,
`endif
    output logic [31:0]          wbs_dat_o,
    output logic                 wb_rd_wr,
    output logic [WIDTH_ADD-1:0] wb_buf_address,
    output logic [31:0]          wb_wr_data,
    input  logic [31:0]          ob_rd_data,
    input  logic [31:0]          sa_rd_data
);
    localparam int CW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    state_t               r_state, w_next;
    logic [WIDTH_ADD-1:0] r_addr;
    logic                 r_we;
    logic [CW-1:0]        r_cnt;
    logic [WIDTH_ADD-1:0] w_adr;
    logic [31:0]          w_rd_data;
    logic                 w_hit, w_busy, w_ok, w_unused;
    assign w_unused = ^{wbs_sel_i, wbs_adr_i[1:0]};
    assign w_adr    = wbs_adr_i[WIDTH_ADD+1:2];
`ifdef WB_IMC_ERR_EN
    assign w_busy = wbs_ack_o | wbs_err_o;
    assign w_ok   = is_mapped(8'(w_adr));
`else
    assign w_busy = wbs_ack_o;
    assign w_ok   = 1'b1;
`endif
    // outputs still high from the previous response block a stale strobe
    assign w_hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:10] == BASE_ADDR[31:10]) & ~w_busy;

    wb_imc_rd_mux #(.WIDTH_ADD(WIDTH_ADD)) u_rd_mux (
        .i_addr (r_addr),
        .i_ob   (ob_rd_data),
        .i_sa   (sa_rd_data),
        .o_data (w_rd_data)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_hit ? (w_ok ? ACCESS : ERR) : IDLE;
            ACCESS:  w_next = !wbs_cyc_i ? IDLE : r_we ? ACK : WAIT;
            WAIT:    w_next = !wbs_cyc_i ? IDLE : (r_cnt == '0) ? ACK : WAIT;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i)
        if (wb_rst_i) r_state <= IDLE;
        else          r_state <= w_next;

    // outputs are decoded from the current state and registered, so they trail the state by one cycle
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_addr         <= '0;
            r_we           <= 1'b0;
            r_cnt          <= '0;
            wbs_ack_o      <= 1'b0;
            wbs_dat_o      <= '0;
            wb_rd_wr       <= 1'b1;
            wb_buf_address <= IDLE_ADDR;
            wb_wr_data     <= '0;
`ifdef WB_IMC_ERR_EN
            wbs_err_o      <= 1'b0;
`endif
        end else begin
            if (r_state == IDLE && w_next == ACCESS) begin
                r_addr <= w_adr;
                r_we   <= wbs_we_i;
                if (wbs_we_i) wb_wr_data <= wbs_dat_i;
            end
            r_cnt <= (r_state == WAIT) ? r_cnt - 1'b1 : CW'(RD_LATENCY - 1);
            if (r_state == WAIT && w_next == ACK) wbs_dat_o <= w_rd_data;
            wbs_ack_o      <= (r_state == ACK);
            wb_rd_wr       <= (r_state == ACCESS) ? r_we : 1'b1;
            wb_buf_address <= (r_state == ACCESS) ? r_addr : IDLE_ADDR;
`ifdef WB_IMC_ERR_EN
            wbs_err_o      <= (r_state == ERR);
`endif
        end
    end
endmodule

// File: tb/tb_wb_imc_slave_ctrl.sv
// tb_wb_imc_slave_ctrl: scoreboard bench for two wb_imc_slave_ctrl instances (RD_LATENCY 1 and 3)
module tb_wb_imc_slave_ctrl;
    typedef struct {
        int          c0;
        int          kind;
        logic [31:0] data;
        logic [31:0] wdata;
    } exp_t;
    typedef struct {
        int         c;
        logic [7:0] a;
        logic       w;
    } pul_t;
    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [31:0] d;
        logic [31:0] rd;
        logic        unm;
    } vec_t;

    logic        clk = 0, rst = 1;
    logic        cyc_i [2];
    logic        stb_i [2];
    logic        we_i = 0;
    logic [31:0] adr_i = 0, dat_i = 0;
    logic [31:0] ob = 32'h1234_5678, sa = 32'hA5A5_0001;
    logic        ack [2];
    logic        rdwr [2];
    logic [31:0] dat [2];
    logic [31:0] wd [2];
    logic [7:0]  badr [2];
`ifdef WB_IMC_ERR_EN
    logic        errv [2];
`endif
    int          cyc = 0, n_chk = 0, n_pass = 0;
    int          rs [2];
    int          rp [2];
    exp_t        sb [$];
    pul_t        pq [$];
    logic [31:0] wexp = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    wb_imc_slave_ctrl #(.RD_LATENCY(1)) u0 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc_i[0]), .wbs_stb_i(stb_i[0]),
        .wbs_we_i(we_i), .wbs_sel_i(4'hF), .wbs_adr_i(adr_i), .wbs_dat_i(dat_i),
        .wbs_ack_o(ack[0]),
`ifdef WB_IMC_ERR_EN
        .wbs_err_o(errv[0]),
`endif
        .wbs_dat_o(dat[0]), .wb_rd_wr(rdwr[0]), .wb_buf_address(badr[0]),
        .wb_wr_data(wd[0]), .ob_rd_data(ob), .sa_rd_data(sa)
    );
    wb_imc_slave_ctrl #(.RD_LATENCY(3)) u1 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc_i[1]), .wbs_stb_i(stb_i[1]),
        .wbs_we_i(we_i), .wbs_sel_i(4'hF), .wbs_adr_i(adr_i), .wbs_dat_i(dat_i),
        .wbs_ack_o(ack[1]),
`ifdef WB_IMC_ERR_EN
        .wbs_err_o(errv[1]),
`endif
        .wbs_dat_o(dat[1]), .wb_rd_wr(rdwr[1]), .wb_buf_address(badr[1]),
        .wb_wr_data(wd[1]), .ob_rd_data(ob), .sa_rd_data(sa)
    );

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) $display("FAIL %s: got %h expected %h at cycle %0d", n, a, e, cyc);
        else n_pass++;
    endtask

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    always @(negedge clk) if (!rst) for (int k = 0; k < 2; k++) begin : mon
        exp_t e;
        pul_t p;
        if (ack[k]) begin
            if (rs[k] >= sb.size()) chk("ack_unexpected", 32'(k), 32'hFFFF_FFFF);
            else begin
                e = sb[rs[k]];
                rs[k]++;
                chk("ack_kind", 32'(e.kind == 2), 32'd0);
                chk("ack_cycle", 32'(cyc), 32'(e.c0 + 2 + ((e.kind == 1) ? lat(k) : 0)));
                if (e.kind == 1) chk("rd_data", dat[k], e.data);
                chk("wr_data", wd[k], e.wdata);
            end
        end
`ifdef WB_IMC_ERR_EN
        if (errv[k]) begin
            if (rs[k] >= sb.size()) chk("err_unexpected", 32'(k), 32'hFFFF_FFFF);
            else begin
                e = sb[rs[k]];
                rs[k]++;
                chk("err_kind", 32'(e.kind), 32'd2);
                chk("err_cycle", 32'(cyc), 32'(e.c0 + 1));
            end
        end
`endif
        if (!rdwr[k] || badr[k] != 8'h00) begin
            if (rp[k] >= pq.size()) chk("pulse_unexpected", {badr[k], 23'd0, rdwr[k]}, 32'hFFFF_FFFF);
            else begin
                p = pq[rp[k]];
                rp[k]++;
                chk("pulse_cycle", 32'(cyc), 32'(p.c));
                chk("pulse_addr", 32'(badr[k]), 32'(p.a));
                chk("pulse_rd_wr", 32'(rdwr[k]), 32'(p.w));
            end
        end
    end

    task automatic wait_resp(input int k);
        bit done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
`ifdef WB_IMC_ERR_EN
            done = ack[k] | errv[k];
`else
            done = ack[k];
`endif
        end
        if (!done) chk("resp_timeout", 32'(k), 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        cyc_i[k] = 0;
        stb_i[k] = 0;
    endtask

    task automatic xfer(input vec_t v);
        bit er = 0;
`ifdef WB_IMC_ERR_EN
        er = v.unm;
`endif
        if (v.we && !er) wexp = v.d;
        sb.push_back('{cyc + 1, er ? 2 : (v.we ? 0 : 1), v.rd, wexp});
        if (!er) pq.push_back('{cyc + 2, v.adr[9:2], v.we});
        adr_i = v.adr; we_i = v.we; dat_i = v.d;
        cyc_i = '{1, 1}; stb_i = '{1, 1};
        fork
            wait_resp(0);
            wait_resp(1);
        join
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset();
        for (int k = 0; k < 2; k++) begin
            chk("rst_ack", 32'(ack[k]), 32'd0);
            chk("rst_dat", dat[k], 32'd0);
            chk("rst_rd_wr", 32'(rdwr[k]), 32'd1);
            chk("rst_addr", 32'(badr[k]), 32'd0);
            chk("rst_wr_data", wd[k], 32'd0);
        end
    endtask

    vec_t vecs [7] = '{
        '{32'h3000_00C4, 1'b1, 32'hDEAD_BEEF, 32'h0,         1'b0},
        '{32'h3000_00CC, 1'b0, 32'h0,         32'h1234_5678, 1'b0},
        '{32'h3000_0104, 1'b0, 32'h0,         32'hA5A5_0001, 1'b0},
        '{32'h3000_0000, 1'b0, 32'h0,         32'h0,         1'b1},
        '{32'h3000_0100, 1'b1, 32'h0BAD_F00D, 32'h0,         1'b0},
        '{32'h3000_03FC, 1'b1, 32'h1111_2222, 32'h0,         1'b1},
        '{32'h3000_00CC, 1'b0, 32'h0,         32'h1234_5678, 1'b0}
    };

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        cyc_i = '{0, 0}; stb_i = '{0, 0};
        rs = '{0, 0}; rp = '{0, 0};
        repeat (3) @(posedge clk);
        #1;
        chk_reset();
        rst = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                chk("idle_ack", 32'(ack[k]), 32'd0);
                chk("idle_addr", 32'(badr[k]), 32'd0);
                chk("idle_rd_wr", 32'(rdwr[k]), 32'd1);
            end
        end
        @(posedge clk);
        #1;
        foreach (vecs[i]) xfer(vecs[i]);
        // read of 0x41 abandoned during WAIT: pulse still appears, no ack
        pq.push_back('{cyc + 2, 8'h41, 1'b0});
        adr_i = 32'h3000_0104; we_i = 0;
        cyc_i = '{1, 1}; stb_i = '{1, 1};
        repeat (2) @(posedge clk);
        #1;
        cyc_i = '{0, 0}; stb_i = '{0, 0};
        repeat (6) @(posedge clk);
        #1;
        // misses outside the window
        adr_i = 32'h2000_00C4; we_i = 1; dat_i = 32'h5555_AAAA;
        cyc_i = '{1, 1}; stb_i = '{1, 1};
        repeat (6) @(posedge clk);
        #1;
        adr_i = 32'h3000_0400;
        repeat (6) @(posedge clk);
        #1;
        cyc_i = '{0, 0}; stb_i = '{0, 0};
        @(posedge clk);
        #1;
        // reset while in ACCESS
        adr_i = 32'h3000_00CC; we_i = 0;
        cyc_i = '{1, 1}; stb_i = '{1, 1};
        @(posedge clk);
        #1;
        rst = 1;
        cyc_i = '{0, 0}; stb_i = '{0, 0};
        #1;
        chk_reset();
        @(posedge clk);
        #1;
        rst = 0;
        repeat (8) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("sb_drained", 32'(rs[k]), 32'(sb.size()));
            chk("pulses_drained", 32'(rp[k]), 32'(pq.size()));
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
